mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 clk_50MHz  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cpu_req  input  1  processor requests one access; held until cpu_ack.
REQ-006 cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-007 cpu_addr  input  ADDR_W  processor access address; stable while cpu_req is high.
REQ-008 cpu_wdata  input  DATA_W  processor write data; stable while cpu_req is high.
REQ-009 cpu_ack  output  1  one-cycle completion pulse to the processor.
REQ-010 cpu_rdata  output  DATA_W  last read data returned to the processor.
REQ-011 ext_req, ext_we, ext_addr, ext_wdata, ext_ack, ext_rdata  same directions and widths as the cpu_* ports  identical port set for the external loader/debug requester.
REQ-012 mem_addr  output  ADDR_W  registered address to the synchronous single-port RAM.
REQ-013 mem_data  output  DATA_W  registered write data to the RAM.
REQ-014 mem_wren  output  1  registered write enable to the RAM.
REQ-015 mem_q  input  DATA_W  RAM read data, valid one clock after the RAM samples the address.
REQ-016 gnt  output  2  one-hot owner of the current transaction: bit0 = cpu, bit1 = ext, 00 = idle.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states are IDLE, ISSUE, WAIT and ACK; every access takes exactly 4 cycles, IDLE through ACK.
REQ-019 IDLE: if any req is high at the rising edge, the arbiter picks a winner, loads mem_addr/mem_data/mem_wren from the winner (mem_wren = winner's we), sets gnt, and goes to ISSUE; otherwise it stays in IDLE with mem_wren = 0.
REQ-020 ISSUE: memory signals are held for one cycle (the RAM samples them at the closing edge); at that edge mem_wren is cleared and the FSM goes to WAIT.
REQ-021 WAIT: at the closing edge, on a read, mem_q is captured into the winner's rdata register; the FSM goes to ACK.
REQ-022 ACK: the winner's ack is high for exactly this cycle; at the closing edge gnt is cleared and the FSM goes to IDLE.
REQ-023 A write does not change either rdata register.
REQ-024 Arbitration is round-robin: with both reqs high in IDLE, the requester not granted last wins; a lone request wins immediately.
REQ-025 The last-grant pointer updates only when a grant is made.
REQ-026 Requests are sampled only in IDLE; a req that rises during ISSUE/WAIT/ACK waits for the next IDLE.
REQ-027 A requester must drop req at the edge closing its ACK cycle; a req still high in the following IDLE is treated as a new access.
REQ-028 The non-winning ack is never asserted, and at most one ack is high in any cycle.
REQ-029 mem_addr and mem_data keep their last values in IDLE; only mem_wren is forced to 0.
REQ-030 Back-to-back: with both reqs continuously re-asserted, grants alternate cpu, ext, cpu, ... at one grant every 4 cycles.

Reset
REQ-031 While reset_n is low: state = IDLE; mem_wren, cpu_ack, ext_ack, gnt and busy = 0; mem_addr, mem_data, cpu_rdata and ext_rdata = 0; the last-grant pointer = ext, so cpu has first priority.
REQ-032 Reset asserted mid-access aborts the access immediately: mem_wren drops without waiting for a clock, and no ack is issued for the aborted access.
REQ-033 After reset_n rises, the first rising edge behaves as IDLE.

Structure
REQ-034 A shared package holds the state enumeration (IDLE, ISSUE, WAIT, ACK), the defaults ADDR_W = 8 and DATA_W = 16, and the requester index constants REQ_CPU = 0 and REQ_EXT = 1.
REQ-035 One sub-module, rr_pick, holds the combinational two-way round-robin selection from {reqs, last_grant} to a one-hot winner; the FSM and all registers stay in mem_arbiter.

Verification
REQ-036 cpu read: preload RAM[0x12] = 0xBEEF; cpu_req with cpu_addr = 0x12 -> mem_addr = 0x12 in ISSUE, cpu_ack 3 cycles after grant, cpu_rdata = 0xBEEF, ext_ack stays 0.
REQ-037 ext write then cpu read: ext writes 0x5A5A to 0x40 -> mem_wren high for exactly 1 cycle, ext_ack pulses once; cpu then reads 0x40 -> 0x5A5A, and ext_rdata is unchanged.
REQ-038 Contention: both reqs rise in the same cycle after reset -> cpu is granted first, then ext, then cpu, spaced 4 cycles apart; gnt is one-hot and never 11.
REQ-039 Late request: ext_req rises in the WAIT state of a cpu access -> ext is not granted until the following IDLE, then completes normally.
REQ-040 Reset mid-write: reset_n driven low during ISSUE of a write -> mem_wren = 0 with no clock edge, no ack pulses, and all outputs at their reset values.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Holds the FSM state encoding, default bus widths and requester indices.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  localparam int REQ_CPU = 0;
  localparam int REQ_EXT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin selector: turns {ext_req, cpu_req} plus the last winner
// into a one-hot grant; on contention the requester not granted last wins.
module rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] win
);

  // Lone requests win outright; ties go to whoever did not win last time.
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = (last_grant == 1'(REQ_EXT)) ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between a
// processor and an external loader; each access runs IDLE, ISSUE, WAIT, ACK.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_50MHz,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [1:0]        gnt,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_wren_q, mem_wren_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              ext_ack_q, ext_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  logic              busy_q, busy_d;
  logic [1:0]        win_s;

  rr_pick u_rr_pick (
    .req        ({ext_req, cpu_req}),
    .last_grant (last_q),
    .win        (win_s)
  );

  // Next-state and output computation for the four-phase access sequence.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    wr_d        = wr_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_wren_d  = 1'b0;
    cpu_ack_d   = 1'b0;
    ext_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    case (state_q)
      IDLE: begin
        if (win_s != 2'b00) begin
          gnt_d  = win_s;
          last_d = win_s[REQ_EXT];
          if (win_s[REQ_EXT]) begin
            mem_addr_d = ext_addr;
            mem_data_d = ext_wdata;
            wr_d       = ext_we;
          end else begin
            mem_addr_d = cpu_addr;
            mem_data_d = cpu_wdata;
            wr_d       = cpu_we;
          end
          mem_wren_d = wr_d;
          state_d    = ISSUE;
        end else begin
          gnt_d   = 2'b00;
          state_d = IDLE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // RAM output registered at the end of ISSUE is valid here.
        if (!wr_q && gnt_q[REQ_CPU]) begin
          cpu_rdata_d = mem_q;
        end else if (!wr_q && gnt_q[REQ_EXT]) begin
          ext_rdata_d = mem_q;
        end else begin
          cpu_rdata_d = cpu_rdata_q;
        end
        cpu_ack_d = gnt_q[REQ_CPU];
        ext_ack_d = gnt_q[REQ_EXT];
        state_d   = ACK;
      end
      ACK: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      last_q      <= 1'(REQ_EXT);
      wr_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_wren_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ext_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      wr_q        <= wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_wren_q  <= mem_wren_d;
      cpu_ack_q   <= cpu_ack_d;
      ext_ack_q   <= ext_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_wren  = mem_wren_q;
  assign cpu_ack   = cpu_ack_q;
  assign ext_ack   = ext_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ext_rdata = ext_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter, checked every cycle against a
// transaction-level model (cycle count since grant plus a shadow memory).
module tb_mem_arbiter;

  logic        clk_50MHz = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [7:0]  cpu_addr, ext_addr;
  logic [15:0] cpu_wdata, ext_wdata;
  logic        cpu_ack, ext_ack, mem_wren, busy;
  logic [15:0] cpu_rdata, ext_rdata, mem_data, mem_q;
  logic [7:0]  mem_addr;
  logic [1:0]  gnt;

  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;
  logic [15:0] ram [0:255];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model: m_cnt = cycles since grant (0 = idle)
  int          m_cnt, m_own, m_last;
  logic        m_we;
  logic [7:0]  m_addr;
  logic [15:0] m_data, e_crd, e_erd;
  logic [15:0] shadow [0:255];

  logic        auto_cpu, auto_ext;
  logic [1:0]  prev_gnt;
  logic [1:0]  glog [$];
  int          gcyc [$];

  always #10 clk_50MHz = ~clk_50MHz;

  mem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk_50MHz(clk_50MHz), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .gnt(gnt), .busy(busy)
  );

  // synchronous single-port RAM, with a bench-side preload port
  always @(posedge clk_50MHz) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_wren) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_own = 0; m_last = 1; m_we = 1'b0;
    m_addr = 8'h00; m_data = 16'h0000; e_crd = 16'h0000; e_erd = 16'h0000;
  endtask

  task automatic model_edge(input logic cr, input logic cw, input logic [7:0] ca,
                            input logic [15:0] cd, input logic er, input logic ew,
                            input logic [7:0] ea, input logic [15:0] ed);
    if (m_cnt == 0) begin
      if (cr || er) begin
        if (cr && er) m_own = (m_last == 1) ? 0 : 1;
        else m_own = cr ? 0 : 1;
        m_last = m_own;
        m_we   = (m_own == 1) ? ew : cw;
        m_addr = (m_own == 1) ? ea : ca;
        m_data = (m_own == 1) ? ed : cd;
        m_cnt  = 1;
      end
    end else if (m_cnt == 1) begin
      if (m_we) shadow[m_addr] = m_data;
      m_cnt = 2;
    end else if (m_cnt == 2) begin
      if (!m_we) begin
        if (m_own == 0) e_crd = shadow[m_addr];
        else e_erd = shadow[m_addr];
      end
      m_cnt = 3;
    end else begin
      m_cnt = 0;
    end
  endtask

  task automatic compare_all();
    check_eq("gnt", 32'(gnt), (m_cnt == 0) ? 32'd0 : ((m_own == 1) ? 32'd2 : 32'd1));
    check_eq("busy", 32'(busy), 32'(m_cnt != 0));
    check_eq("mem_wren", 32'(mem_wren), 32'(m_cnt == 1 && m_we));
    check_eq("cpu_ack", 32'(cpu_ack), 32'(m_cnt == 3 && m_own == 0));
    check_eq("ext_ack", 32'(ext_ack), 32'(m_cnt == 3 && m_own == 1));
    check_eq("mem_addr", 32'(mem_addr), 32'(m_addr));
    check_eq("mem_data", 32'(mem_data), 32'(m_data));
    check_eq("cpu_rdata", 32'(cpu_rdata), 32'(e_crd));
    check_eq("ext_rdata", 32'(ext_rdata), 32'(e_erd));
  endtask

  task automatic step();
    logic cr, cw, er, ew;
    logic [7:0] ca, ea;
    logic [15:0] cd, ed;
    cr = cpu_req; cw = cpu_we; ca = cpu_addr; cd = cpu_wdata;
    er = ext_req; ew = ext_we; ea = ext_addr; ed = ext_wdata;
    @(posedge clk_50MHz);
    cyc++;
    if (!reset_n) model_reset();
    else model_edge(cr, cw, ca, cd, er, ew, ea, ed);
    #1;
    compare_all();
    if (gnt != 2'b00 && prev_gnt == 2'b00) begin
      glog.push_back(gnt);
      gcyc.push_back(cyc);
    end
    prev_gnt = gnt;
    if (cpu_ack) cpu_req = 1'b0;
    else if (auto_cpu && !cpu_req) cpu_req = 1'b1;
    if (ext_ack) ext_req = 1'b0;
    else if (auto_ext && !ext_req) ext_req = 1'b1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk_50MHz);
    #1;
    pre_en = 1'b0;
    shadow[a] = d;
  endtask

  task automatic cpu_start(input logic we, input logic [7:0] a, input logic [15:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic ext_start(input logic we, input logic [7:0] a, input logic [15:0] d);
    ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_n = 1'b0; pre_en = 1'b0; pre_addr = 8'h00; pre_data = 16'h0000;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 8'h00; ext_wdata = 16'h0000;
    auto_cpu = 1'b0; auto_ext = 1'b0; prev_gnt = 2'b00;
    model_reset();
    #5;
    compare_all();
    for (int i = 0; i < 16; i++) preload(8'(i), 16'(i * 16'h0111));
    preload(8'h12, 16'hBEEF);
    preload(8'h40, 16'h0000);
    reset_n = 1'b1;

    // cpu read of a preloaded location
    cpu_start(1'b0, 8'h12, 16'h1111);
    run(6);
    check_eq("cpu_rd_beef", 32'(cpu_rdata), 32'h0000BEEF);

    // ext write followed by cpu read of the same word
    ext_start(1'b1, 8'h40, 16'h5A5A);
    run(5);
    cpu_start(1'b0, 8'h40, 16'h0000);
    run(6);
    check_eq("cpu_rd_5a5a", 32'(cpu_rdata), 32'h00005A5A);
    check_eq("ext_rd_keep", 32'(ext_rdata), 32'h00000000);

    // contention right after reset, continuously re-asserted
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
    glog.delete(); gcyc.delete();
    cpu_start(1'b0, 8'h03, 16'h0000);
    ext_start(1'b0, 8'h05, 16'h0000);
    auto_cpu = 1'b1; auto_ext = 1'b1;
    run(12);
    auto_cpu = 1'b0; auto_ext = 1'b0;
    run(10);
    check_eq("cont_grants", 32'(glog.size() >= 3), 32'd1);
    if (glog.size() >= 3) begin
      check_eq("cont_g0", 32'(glog[0]), 32'd1);
      check_eq("cont_g1", 32'(glog[1]), 32'd2);
      check_eq("cont_g2", 32'(glog[2]), 32'd1);
      check_eq("cont_sp1", 32'(gcyc[1] - gcyc[0]), 32'd4);
      check_eq("cont_sp2", 32'(gcyc[2] - gcyc[1]), 32'd4);
    end

    // ext request arriving in the WAIT phase of a cpu access
    glog.delete(); gcyc.delete();
    cpu_start(1'b0, 8'h12, 16'h0000);
    run(2);
    ext_start(1'b0, 8'h12, 16'h0000);
    run(10);
    check_eq("late_grants", 32'(glog.size()), 32'd2);
    if (glog.size() >= 2) begin
      check_eq("late_g0", 32'(glog[0]), 32'd1);
      check_eq("late_g1", 32'(glog[1]), 32'd2);
      check_eq("late_sp", 32'(gcyc[1] - gcyc[0]), 32'd4);
    end
    check_eq("late_ext_rd", 32'(ext_rdata), 32'h0000BEEF);

    // reset asserted during ISSUE of a write
    cpu_start(1'b1, 8'h07, 16'hDEAD);
    step();
    check_eq("issue_wren", 32'(mem_wren), 32'd1);
    #2;
    reset_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    check_eq("rst_wren_async", 32'(mem_wren), 32'd0);
    model_reset();
    compare_all();
    run(3);
    reset_n = 1'b1;
    run(3);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      if (!cpu_req && $urandom_range(0, 2) == 0)
        cpu_start(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
      if (!ext_req && $urandom_range(0, 2) == 0)
        ext_start(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
      step();
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    run(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
